// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle RV32I control sequencer.
// Holds the FSM state enum, the opcode constants and the encodings of every
// datapath select and of the ALU operation field.
package mc_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned OP_W    = 7;
    localparam int unsigned SEL_W   = 2;
    localparam int unsigned ALUC_W  = 3;

    typedef enum logic [STATE_W-1:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECR, EXECI, ALUWB, BEQ, JAL, TRAP
    } state_t;

    // Which operation the FSM asks of the ALU decoder
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [OP_W-1:0] OP_LW    = 7'b0000011;
    localparam logic [OP_W-1:0] OP_SW    = 7'b0100011;
    localparam logic [OP_W-1:0] OP_RTYPE = 7'b0110011;
    localparam logic [OP_W-1:0] OP_ITYPE = 7'b0010011;
    localparam logic [OP_W-1:0] OP_BEQ   = 7'b1100011;
    localparam logic [OP_W-1:0] OP_JAL   = 7'b1101111;

    localparam logic [ALUC_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALUC_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALUC_W-1:0] ALU_AND = 3'b010;
    localparam logic [ALUC_W-1:0] ALU_OR  = 3'b011;
    localparam logic [ALUC_W-1:0] ALU_SLT = 3'b101;

    localparam logic [SEL_W-1:0] IMM_I = 2'b00;
    localparam logic [SEL_W-1:0] IMM_S = 2'b01;
    localparam logic [SEL_W-1:0] IMM_B = 2'b10;
    localparam logic [SEL_W-1:0] IMM_J = 2'b11;

    localparam logic [SEL_W-1:0] RES_ALUOUT    = 2'b00;
    localparam logic [SEL_W-1:0] RES_DATA      = 2'b01;
    localparam logic [SEL_W-1:0] RES_ALURESULT = 2'b10;

    localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
    localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
    localparam logic [SEL_W-1:0] SRCA_RS1   = 2'b10;

    localparam logic [SEL_W-1:0] SRCB_RS2  = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/alu_op_decoder.sv
// ALU operation decoder.
// Ports: aluop (add/sub/funct request from the FSM), op5 (opcode bit 5,
// distinguishes R-type from I-type), func3, func7 (instr[30]) ->
// alu_control (3-bit ALU operation).
module alu_op_decoder
    import mc_pkg::*;
(
    input  aluop_t              aluop,
    input  logic                op5,
    input  logic [2:0]          func3,
    input  logic                func7,
    output logic [ALUC_W-1:0]   alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (aluop)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (func3)
                    // instr[30] is an immediate bit for I-type, so only R-type may subtract
                    3'b000:  alu_control = (op5 && func7) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle control sequencer (Moore FSM) for the RV32I subset core.
// Inputs: clk, reset (async, active-high), opcode/func3/func7 from the
// instruction register, zero flag, mem_ready handshake.
// Outputs (combinational): write strobes PCWrite/IRWrite/RegWrite/MemWrite,
// selects AdrSrc/ResultSrc/ALUSrcA/ALUSrcB/ImmSrc, ALUControl, instr_done
// pulse in each instruction's final cycle, trap while halted.
module mc_controller
    import mc_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [OP_W-1:0]     opcode,
    input  logic [2:0]          func3,
    input  logic                func7,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                PCWrite,
    output logic                IRWrite,
    output logic                RegWrite,
    output logic                MemWrite,
    output logic                AdrSrc,
    output logic [SEL_W-1:0]    ResultSrc,
    output logic [SEL_W-1:0]    ALUSrcA,
    output logic [SEL_W-1:0]    ALUSrcB,
    output logic [SEL_W-1:0]    ImmSrc,
    output logic [ALUC_W-1:0]   ALUControl,
    output logic                instr_done,
    output logic                trap
);

    state_t state, state_next;
    aluop_t aluop;
    logic   pc_wr, ir_wr, reg_wr, mem_wr, done, in_trap;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FETCH;
        else       state <= state_next;
    end

    // Next-state and per-state outputs
    always_comb begin
        state_next = state;
        aluop      = ALUOP_ADD;
        pc_wr      = 1'b0;
        ir_wr      = 1'b0;
        reg_wr     = 1'b0;
        mem_wr     = 1'b0;
        done       = 1'b0;
        in_trap    = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_RS2;
        case (state)
            FETCH: begin
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                ir_wr     = mem_ready;
                pc_wr     = mem_ready;
                if (mem_ready) state_next = DECODE;
            end
            DECODE: begin
                // Speculatively form the branch/jump target from OldPC + imm
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (opcode)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_RTYPE:     state_next = EXECR;
                    OP_ITYPE:     state_next = EXECI;
                    OP_BEQ:       state_next = BEQ;
                    OP_JAL:       state_next = JAL;
                    default:      state_next = TRAP;
                endcase
            end
            MEMADR: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_IMM;
                state_next = (opcode == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                AdrSrc = 1'b1;
                if (mem_ready) state_next = MEMWB;
            end
            MEMWRITE: begin
                AdrSrc = 1'b1;
                mem_wr = 1'b1;
                done   = mem_ready;
                if (mem_ready) state_next = FETCH;
            end
            MEMWB: begin
                ResultSrc  = RES_DATA;
                reg_wr     = 1'b1;
                done       = 1'b1;
                state_next = FETCH;
            end
            EXECR: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_RS2;
                aluop      = ALUOP_FUNCT;
                state_next = ALUWB;
            end
            EXECI: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_IMM;
                aluop      = ALUOP_FUNCT;
                state_next = ALUWB;
            end
            ALUWB: begin
                reg_wr     = 1'b1;
                done       = 1'b1;
                state_next = FETCH;
            end
            BEQ: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_RS2;
                aluop      = ALUOP_SUB;
                pc_wr      = zero;
                done       = 1'b1;
                state_next = FETCH;
            end
            JAL: begin
                // ALU forms the link value OldPC + 4; PC takes the target held in ALUOut
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_FOUR;
                pc_wr      = 1'b1;
                state_next = ALUWB;
            end
            TRAP: begin
                in_trap = 1'b1;
            end
            default: state_next = TRAP;
        endcase
    end

    // Immediate format follows the opcode directly
    always_comb begin
        ImmSrc = IMM_I;
        case (opcode)
            OP_SW:   ImmSrc = IMM_S;
            OP_BEQ:  ImmSrc = IMM_B;
            OP_JAL:  ImmSrc = IMM_J;
            default: ImmSrc = IMM_I;
        endcase
    end

    alu_op_decoder u_alu_op_decoder (
        .aluop       (aluop),
        .op5         (opcode[5]),
        .func3       (func3),
        .func7       (func7),
        .alu_control (ALUControl)
    );

    // No strobe may fire while reset is held, even with mem_ready high
    assign PCWrite    = pc_wr   & ~reset;
    assign IRWrite    = ir_wr   & ~reset;
    assign RegWrite   = reg_wr  & ~reset;
    assign MemWrite   = mem_wr  & ~reset;
    assign instr_done = done    & ~reset;
    assign trap       = in_trap & ~reset;

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: every instruction is expanded into a
// per-cycle script of expected outputs and mem_ready values, then replayed.
module tb_mc_controller;

    logic       clk, reset;
    logic [6:0] opcode;
    logic [2:0] func3;
    logic       func7, zero, mem_ready;
    logic       PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic       instr_done, trap;

    mc_controller dut (
        .clk(clk), .reset(reset), .opcode(opcode), .func3(func3), .func7(func7),
        .zero(zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .AdrSrc(AdrSrc),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ImmSrc(ImmSrc), .ALUControl(ALUControl), .instr_done(instr_done),
        .trap(trap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcw, irw, rw, mw, adr;
        logic [1:0] res, a, b, imm;
        logic [2:0] alu;
        logic       done, trp;
    } outs_t;

    localparam logic [6:0] R_OP   = 7'b0110011;
    localparam logic [6:0] I_OP   = 7'b0010011;
    localparam logic [6:0] LW_OP  = 7'b0000011;
    localparam logic [6:0] SW_OP  = 7'b0100011;
    localparam logic [6:0] BEQ_OP = 7'b1100011;
    localparam logic [6:0] JAL_OP = 7'b1101111;
    localparam logic [6:0] BAD_OP = 7'b1110011;

    int checks = 0;
    int failures = 0;

    bit    mr_q[$];
    outs_t exp_q[$];
    string tag_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%05h exp=%05h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic outs_t observe();
        outs_t o;
        o.pcw = PCWrite;  o.irw = IRWrite; o.rw = RegWrite; o.mw = MemWrite;
        o.adr = AdrSrc;   o.res = ResultSrc; o.a = ALUSrcA; o.b = ALUSrcB;
        o.imm = ImmSrc;   o.alu = ALUControl; o.done = instr_done; o.trp = trap;
        return o;
    endfunction

    function automatic logic [1:0] imm_of(input logic [6:0] op);
        if (op == SW_OP)  return 2'b01;
        if (op == BEQ_OP) return 2'b10;
        if (op == JAL_OP) return 2'b11;
        return 2'b00;
    endfunction

    // Arithmetic op chosen by funct fields; only R-type may request subtract
    function automatic logic [2:0] alu_of(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        case (f3)
            3'b000:  return (op == R_OP && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    // Outputs expected in FETCH with no strobes (also the reset view)
    function automatic outs_t fetch_idle(input logic [6:0] op);
        outs_t o = '0;
        o.imm = imm_of(op); o.b = 2'b10; o.res = 2'b10;
        return o;
    endfunction

    task automatic push(input string tag, input bit mr, input outs_t o);
        tag_q.push_back(tag); mr_q.push_back(mr); exp_q.push_back(o);
    endtask

    task automatic push_fetch_decode(input logic [6:0] op, input int nf);
        outs_t o;
        for (int i = 0; i < nf; i++) push("fetch_wait", 1'b0, fetch_idle(op));
        o = fetch_idle(op); o.pcw = 1'b1; o.irw = 1'b1;
        push("fetch", 1'b1, o);
        o = '0; o.imm = imm_of(op); o.a = 2'b01; o.b = 2'b01;
        push("decode", 1'($urandom_range(0, 1)), o);
    endtask

    task automatic play(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic z);
        bit first = 1'b1;
        outs_t e;
        string t;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            if (first) begin
                opcode = op; func3 = f3; func7 = f7; zero = z;
                first = 1'b0;
            end
            mem_ready = mr_q.pop_front();
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            #2;
            check(t, 32'(observe()), 32'(e));
        end
    endtask

    // kind: 0 R, 1 I, 2 lw, 3 sw, 4 beq, 5 jal, 6 illegal
    task automatic do_instr(input int kind, input logic [2:0] f3, input logic f7,
                            input logic z, input int nf, input int nm);
        logic [6:0] op;
        outs_t base, o;
        case (kind)
            0: op = R_OP;   1: op = I_OP;   2: op = LW_OP; 3: op = SW_OP;
            4: op = BEQ_OP; 5: op = JAL_OP; default: op = BAD_OP;
        endcase
        base = '0; base.imm = imm_of(op);
        push_fetch_decode(op, nf);
        if (kind == 2 || kind == 3) begin
            o = base; o.a = 2'b10; o.b = 2'b01;
            push("memadr", 1'($urandom_range(0, 1)), o);
        end
        case (kind)
            0, 1: begin
                o = base; o.a = 2'b10; o.b = (kind == 0) ? 2'b00 : 2'b01; o.alu = alu_of(op, f3, f7);
                push(kind == 0 ? "execr" : "execi", 1'($urandom_range(0, 1)), o);
            end
            2: begin
                o = base; o.adr = 1'b1;
                for (int i = 0; i < nm; i++) push("memread_wait", 1'b0, o);
                push("memread", 1'b1, o);
                o = base; o.res = 2'b01; o.rw = 1'b1; o.done = 1'b1;
                push("memwb", 1'($urandom_range(0, 1)), o);
            end
            3: begin
                o = base; o.adr = 1'b1; o.mw = 1'b1;
                for (int i = 0; i < nm; i++) push("memwrite_wait", 1'b0, o);
                o.done = 1'b1;
                push("memwrite", 1'b1, o);
            end
            4: begin
                o = base; o.a = 2'b10; o.alu = 3'b001; o.pcw = z; o.done = 1'b1;
                push("beq", 1'($urandom_range(0, 1)), o);
            end
            5: begin
                o = base; o.a = 2'b01; o.b = 2'b10; o.pcw = 1'b1;
                push("jal", 1'($urandom_range(0, 1)), o);
            end
            default: begin
                o = base; o.trp = 1'b1;
                for (int i = 0; i < 12; i++) push("trap", 1'($urandom_range(0, 1)), o);
            end
        endcase
        if (kind == 0 || kind == 1 || kind == 5) begin
            o = base; o.rw = 1'b1; o.done = 1'b1;
            push("aluwb", 1'($urandom_range(0, 1)), o);
        end
        play(op, f3, f7, z);
    endtask

    // Assert reset with mem_ready high, check the FETCH view, release with mem_ready low
    task automatic reset_pulse(input string tag);
        @(negedge clk);
        reset = 1'b1; mem_ready = 1'b1;
        #2 check(tag, 32'(observe()), 32'(fetch_idle(opcode)));
        @(negedge clk);
        #2 check({tag, "_hold"}, 32'(observe()), 32'(fetch_idle(opcode)));
        @(negedge clk);
        mem_ready = 1'b0; reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; mem_ready = 1'b0; opcode = R_OP; func3 = 3'b000; func7 = 1'b0; zero = 1'b0;
        #1 reset = 1'b1; mem_ready = 1'b1;
        #2 check("reset", 32'(observe()), 32'(fetch_idle(opcode)));
        @(negedge clk);
        mem_ready = 1'b0; reset = 1'b0;

        // Directed cases
        do_instr(0, 3'b000, 1'b1, 1'b0, 0, 0);   // sub
        do_instr(1, 3'b000, 1'b1, 1'b0, 0, 0);   // addi with instr[30]=1
        do_instr(0, 3'b010, 1'b0, 1'b0, 1, 0);   // slt
        do_instr(0, 3'b110, 1'b0, 1'b0, 0, 0);   // or
        do_instr(1, 3'b111, 1'b0, 1'b0, 0, 0);   // andi
        do_instr(0, 3'b001, 1'b1, 1'b0, 0, 0);   // unlisted func3 -> add
        do_instr(2, 3'b010, 1'b0, 1'b0, 0, 2);   // lw, 2 wait cycles
        do_instr(3, 3'b010, 1'b0, 1'b0, 0, 3);   // sw, 3 wait cycles
        do_instr(4, 3'b000, 1'b0, 1'b1, 0, 0);   // beq taken
        do_instr(4, 3'b000, 1'b0, 1'b0, 0, 0);   // beq not taken
        do_instr(5, 3'b000, 1'b0, 1'b0, 0, 0);   // jal

        // Reset in the middle of an R-type, while in EXECR
        push_fetch_decode(R_OP, 0);
        play(R_OP, 3'b000, 1'b1, 1'b0);
        reset_pulse("reset_in_execr");
        do_instr(0, 3'b111, 1'b0, 1'b0, 1, 0);

        // Illegal opcode halts until reset
        do_instr(6, 3'b000, 1'b0, 1'b0, 0, 0);
        reset_pulse("reset_from_trap");
        do_instr(2, 3'b000, 1'b0, 1'b0, 0, 0);

        // Randomized instruction stream
        for (int n = 0; n < 150; n++) begin
            do_instr(int'($urandom_range(0, 5)), 3'($urandom), 1'($urandom), 1'($urandom),
                     int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multi-cycle control sequencer for the RV32I subset core: R-type, I-type ALU, lw, sw, beq, jal. It replaces the single-cycle decode path with a Moore FSM, so one ALU and one unified memory port are shared across the instruction's phases. It sits between the instruction register/flags and the datapath mux selects and write strobes. Memory is handshaked with `mem_ready`.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `opcode`  in  7  instr[6:0] from the instruction register
- `func3`  in  3  instr[14:12]
- `func7`  in  1  instr[30]
- `zero`  in  1  ALU zero flag
- `mem_ready`  in  1  memory completes the current access this cycle
- `PCWrite`, `IRWrite`, `RegWrite`, `MemWrite`  out  1 each  write strobes
- `AdrSrc`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `ResultSrc`  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
- `ALUSrcA`  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1
- `ALUSrcB`  out  2  ALU B select: 00 = rs2, 01 = imm, 10 = constant 4
- `ImmSrc`  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J
- `ALUControl`  out  3  ALU operation: 000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt
- `instr_done`  out  1  one-cycle pulse in the final state of each instruction
- `trap`  out  1  high while in TRAP

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, TRAP.
- Transitions:
  - FETCH→DECODE when mem_ready; otherwise stay in FETCH.
  - DECODE → MEMADR for lw/sw, EXECR (0110011), EXECI (0010011), BEQ (1100011), JAL (1101111); any other opcode → TRAP.
  - MEMADR→MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD→MEMWB on mem_ready; MEMWRITE→FETCH on mem_ready.
  - MEMWB, ALUWB, BEQ → FETCH. EXECR, EXECI, JAL → ALUWB.
  - TRAP is sticky until reset.
- Per-state outputs. Unlisted strobes are 0; unlisted selects are 00.
  - FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10. IRWrite=PCWrite=mem_ready.
  - DECODE: ALUSrcA=01, ALUSrcB=01, add (branch/jump target).
  - MEMADR: ALUSrcA=10, ALUSrcB=01, add.
  - MEMREAD: AdrSrc=1.
  - MEMWRITE: AdrSrc=1, MemWrite=1, held for every wait cycle.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - EXECR: ALUSrcA=10, ALUSrcB=00, funct-decoded operation.
  - EXECI: ALUSrcA=10, ALUSrcB=01, funct-decoded operation.
  - ALUWB: ResultSrc=00, RegWrite=1.
  - BEQ: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, PCWrite=zero.
  - JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1.
- Funct decode:
  - func3 000 → sub only when opcode[5]=1 and func7=1, else add. For EXECI, func7 is an immediate bit and is ignored.
  - func3 010 → slt, 110 → or, 111 → and. Any other func3 → add.
- ImmSrc is combinational from opcode: 0100011→01, 1100011→10, 1101111→11, else 00.
- instr_done=1 in MEMWB, ALUWB, BEQ, and in MEMWRITE when mem_ready=1.

## Timing
- State register updates on the rising edge of clk. All outputs are combinational from state plus opcode/func/zero/mem_ready; there are no registered outputs.
- Reset is asynchronous: state→FETCH immediately. While reset is high, PCWrite, IRWrite, RegWrite, MemWrite and instr_done are forced to 0, trap=0, and selects take FETCH values.
- Reset mid-instruction abandons the instruction; no strobe fires after reset asserts.
- Cycles per instruction with mem_ready tied high: R/I 4, lw 5, sw 4, beq 3, jal 4.
- Each low cycle of mem_ready in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- opcode/func fields are only sampled after DECODE, so they are stable for the whole instruction.

## Structure
- Package `mc_pkg` holds:
  - the state enum (4-bit encoding);
  - opcode constants;
  - ALUControl, ImmSrc, ResultSrc, ALUSrcA and ALUSrcB encodings.
- One sub-module, `alu_op_decoder`: ALUop (00 add, 01 sub, 10 funct), opcode[5], func3, func7 → ALUControl. The FSM drives ALUop per state.

## Test plan
- reset asserted during EXECR → outputs show FETCH selects immediately with all strobes 0; after release, FETCH proceeds normally.
- sub (0110011, f3=000, f7=1), mem_ready=1 → ALUControl=001 in EXECR, RegWrite in cycle 4, instr_done in cycle 4.
- addi with instr[30]=1 (0010011, f3=000) → ALUControl=000 in EXECI.
- lw with mem_ready low for 2 cycles in MEMREAD → 7 cycles total; RegWrite=1 with ResultSrc=01 exactly once.
- sw with mem_ready low for 3 cycles in MEMWRITE → MemWrite high for 4 consecutive cycles; instr_done coincides with the last of them; ImmSrc=01.
- beq with zero=1 then with zero=0 → PCWrite=1 vs 0 in BEQ; 3 cycles each. jal → PCWrite in JAL, RegWrite in ALUWB, ImmSrc=11.
- opcode 1110011 → TRAP after DECODE; trap=1 and all strobes 0 for ≥10 cycles; reset returns the FSM to FETCH.
